sequence_generator: RTL and testbench
=====================================

SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

Interface
REQ-001 The block SHALL have the parameter PAT_W, default 4, meaning the pattern length in bits (legal range 2..16).
REQ-002 The block SHALL have the parameter CNT_W, default 8, meaning the width of the repeat count.
REQ-003 The block SHALL have the parameter IDLE_BIT, default 1'b1, meaning the line level driven on x whenever no pattern bit is being sent.
REQ-004 The block SHALL have the port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 The block SHALL have the port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have the port start, input, 1 bit: request to begin a burst, sampled only in IDLE.
REQ-007 The block SHALL have the port abort, input, 1 bit: synchronous burst cancel.
REQ-008 The block SHALL have the port pattern, input, PAT_W bits: the bit sequence, sent MSB first.
REQ-009 The block SHALL have the port repeat_cnt, input, CNT_W bits: the number of pattern repetitions per burst.
REQ-010 The block SHALL have the port gap, input, 4 bits: the number of IDLE_BIT cycles inserted between repetitions.
REQ-011 The block SHALL have the port x, output, 1 bit: the registered serial data line, which feeds the downstream Mealy detector input.
REQ-012 The block SHALL have the port x_valid, output, 1 bit: high while x carries a pattern bit.
REQ-013 The block SHALL have the port frame_start, output, 1 bit: a 1-cycle pulse coincident with the MSB of each repetition.
REQ-014 The block SHALL have the port busy, output, 1 bit: high from the cycle after start is accepted until the cycle done pulses (inclusive).
REQ-015 The block SHALL have the port done, output, 1 bit: a 1-cycle pulse when a burst completes normally.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, SEND, GAP, and FIN.
REQ-017 In IDLE with start=1, the block SHALL latch pattern, repeat_cnt, and gap into internal registers; later input changes SHALL have no effect until the next burst.
REQ-018 When start is accepted with repeat_cnt=0, the next state SHALL be FIN, with no bits sent.
REQ-019 When start is accepted with repeat_cnt>0, the next state SHALL be SEND, with the bit index at PAT_W-1 and the remaining count at repeat_cnt.
REQ-020 Latency: if start is sampled at edge k, then after edge k+1, x SHALL equal pattern[PAT_W-1] with x_valid=1 and frame_start=1.
REQ-021 In SEND, x SHALL present one bit per cycle, from MSB to LSB, over exactly PAT_W consecutive cycles.
REQ-022 After the LSB, the remaining count SHALL decrement by 1.
REQ-023 After the LSB, if the result is 0, the next state SHALL be FIN.
REQ-024 After the LSB, if the result is non-zero and gap=0, the block SHALL stay in SEND, restarting at the MSB back-to-back with no idle cycle.
REQ-025 After the LSB, if the result is non-zero and gap>0, the next state SHALL be GAP.
REQ-026 In GAP, x SHALL be IDLE_BIT and x_valid SHALL be 0 for exactly gap cycles, followed by SEND.
REQ-027 In FIN, done SHALL be 1, busy SHALL be 1, x SHALL be IDLE_BIT, and x_valid SHALL be 0 for one cycle, then the state SHALL return to IDLE.
REQ-028 In IDLE, x SHALL be IDLE_BIT; x_valid, frame_start, busy, and done SHALL be 0.
REQ-029 A start received while not in IDLE SHALL be ignored; it SHALL NOT be queued.
REQ-030 A start received in the same cycle as FIN SHALL be ignored; a new burst SHALL be accepted no earlier than the cycle after done.
REQ-031 abort=1 in any state SHALL cause the next state to be IDLE, with x=IDLE_BIT, x_valid=0, busy=0, and no done pulse.
REQ-032 If abort and start are both 1 in IDLE, abort SHALL take priority and the burst SHALL NOT start.
REQ-033 The repeat counter SHALL NOT wrap: repeat_cnt=2^CNT_W-1 SHALL produce exactly that many repetitions.
REQ-034 All outputs SHALL be driven directly from flops; there SHALL be no combinational path from any input to any output.
REQ-035 The total burst length, from the first x_valid to done, SHALL be N*PAT_W + (N-1)*gap + 1 cycles, where N is the latched repeat_cnt and N>0.

Reset
REQ-036 When reset_n=0 at a rising edge, the FSM SHALL go to IDLE and the block SHALL drive x=IDLE_BIT and x_valid=frame_start=busy=done=0.
REQ-037 On reset, the internal bit index, repeat count, gap count, and latched pattern SHALL clear to 0.
REQ-038 Reset SHALL take priority over abort and start.
REQ-039 Reset asserted mid-burst SHALL terminate the burst immediately, with no done pulse.

Verification
REQ-040 With defaults, pattern=4'b0110, repeat_cnt=1, and gap=0, a start pulse SHALL produce x=0,1,1,0 with x_valid=1 on cycles k+1..k+4 and done on cycle k+5; a connected 0110 detector SHALL assert z exactly once, in cycle k+4.
REQ-041 With pattern=0110, repeat_cnt=3, and gap=0, the block SHALL produce 12 contiguous valid bits and 3 frame_start pulses spaced 4 cycles apart, and the detector SHALL report 3 hits.
REQ-042 With pattern=0110, repeat_cnt=2, and gap=3, the block SHALL drive x=1,1,1 with x_valid=0 between the two frames, and done SHALL occur 4+3+4+1=12 cycles after the first valid bit.
REQ-043 With repeat_cnt=0, the block SHALL pulse done on cycle k+1, and x_valid SHALL never assert.
REQ-044 With abort=1 during the 2nd bit of a repetition, the block SHALL be in IDLE on the next cycle with busy=0, no done, and x=1; a following start SHALL be accepted normally.
REQ-045 With reset_n=0 during GAP and start held at 1 throughout, all outputs SHALL be at their reset values and a new burst SHALL begin only after reset_n=1 and start is sampled in IDLE.

Source files
------------

// File: rtl/sequence_generator.sv
// Serial burst generator: shifts a latched pattern out MSB first a set number of times,
// optionally separated by idle gaps. Every output is registered from the current state.
module sequence_generator #(
    parameter int   PAT_W    = 4,
    parameter int   CNT_W    = 8,
    parameter logic IDLE_BIT = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [3:0]       gap,
    output logic             x,
    output logic             x_valid,
    output logic             frame_start,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] MSB_IDX = IDX_W'(PAT_W - 1);

    typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;

    state_t           state_q, state_nx;
    logic [PAT_W-1:0] pat_q, pat_nx;
    logic [IDX_W-1:0] idx_q, idx_nx;
    logic [CNT_W-1:0] rem_q, rem_nx;
    logic [3:0]       gap_len_q, gap_len_nx;
    logic [3:0]       gap_cnt_q, gap_cnt_nx;
    logic             x_nx, x_valid_nx, frame_start_nx, busy_nx, done_nx;

    // State register plus output flops; outputs show the state of the previous cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            pat_q       <= '0;
            idx_q       <= '0;
            rem_q       <= '0;
            gap_len_q   <= '0;
            gap_cnt_q   <= '0;
            x           <= IDLE_BIT;
            x_valid     <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_nx;
            pat_q       <= pat_nx;
            idx_q       <= idx_nx;
            rem_q       <= rem_nx;
            gap_len_q   <= gap_len_nx;
            gap_cnt_q   <= gap_cnt_nx;
            x           <= x_nx;
            x_valid     <= x_valid_nx;
            frame_start <= frame_start_nx;
            busy        <= busy_nx;
            done        <= done_nx;
        end
    end

    // Next-state logic; the burst ends when the last repetition finishes its LSB.
    always_comb begin
        state_nx   = state_q;
        pat_nx     = pat_q;
        idx_nx     = idx_q;
        rem_nx     = rem_q;
        gap_len_nx = gap_len_q;
        gap_cnt_nx = gap_cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    pat_nx     = pattern;
                    rem_nx     = repeat_cnt;
                    gap_len_nx = gap;
                    idx_nx     = MSB_IDX;
                    state_nx   = (repeat_cnt == '0) ? FIN : SEND;
                end
            end
            SEND: begin
                if (idx_q == '0) begin
                    rem_nx = rem_q - CNT_W'(1);
                    idx_nx = MSB_IDX;
                    if (rem_q == CNT_W'(1)) begin
                        state_nx = FIN;
                    end else if (gap_len_q == 4'd0) begin
                        state_nx = SEND;
                    end else begin
                        state_nx   = GAP;
                        gap_cnt_nx = gap_len_q;
                    end
                end else begin
                    idx_nx = idx_q - IDX_W'(1);
                end
            end
            GAP: begin
                if (gap_cnt_q <= 4'd1) begin
                    gap_cnt_nx = 4'd0;
                    state_nx   = SEND;
                end else begin
                    gap_cnt_nx = gap_cnt_q - 4'd1;
                end
            end
            FIN: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        if (abort) begin
            state_nx = IDLE;
        end
    end

    // Output values to register; an abort forces the idle line on the same edge.
    always_comb begin
        x_nx           = IDLE_BIT;
        x_valid_nx     = 1'b0;
        frame_start_nx = 1'b0;
        busy_nx        = 1'b0;
        done_nx        = 1'b0;
        if (!abort) begin
            case (state_q)
                SEND: begin
                    x_nx           = pat_q[idx_q];
                    x_valid_nx     = 1'b1;
                    frame_start_nx = (idx_q == MSB_IDX);
                    busy_nx        = 1'b1;
                end
                GAP: begin
                    busy_nx = 1'b1;
                end
                FIN: begin
                    busy_nx = 1'b1;
                    done_nx = 1'b1;
                end
                default: begin
                    busy_nx = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sequence_generator.sv
// Directed bench for sequence_generator with a 0110 Mealy detector model on the serial line.
module tb_sequence_generator;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       abort;
    logic [3:0] pattern;
    logic [7:0] repeat_cnt;
    logic [3:0] gap;
    logic       x;
    logic       x_valid;
    logic       frame_start;
    logic       busy;
    logic       done;

    int compared   = 0;
    int mismatched = 0;

    int          cyc;
    int          valid_cnt;
    int          first_valid;
    int          fs_cnt;
    int          fs_q[$];
    int          done_cnt;
    int          done_cyc;
    int          idle_busy;
    int          gap_x_bad;
    int          hits;
    int          last_hit;
    logic [3:0]  hist;
    logic [31:0] seen_bits;

    sequence_generator dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .abort       (abort),
        .pattern     (pattern),
        .repeat_cnt  (repeat_cnt),
        .gap         (gap),
        .x           (x),
        .x_valid     (x_valid),
        .frame_start (frame_start),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] outs();
        return {x, x_valid, frame_start, busy, done};
    endfunction

    task automatic checkOutput(input string tag, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic clear_stats();
        cyc         = 0;
        valid_cnt   = 0;
        first_valid = -1;
        fs_cnt      = 0;
        fs_q.delete();
        done_cnt    = 0;
        done_cyc    = -1;
        idle_busy   = 0;
        gap_x_bad   = 0;
        hits        = 0;
        last_hit    = -1;
        hist        = 4'b1111;
        seen_bits   = '0;
    endtask

    // Advance one edge, then sample outputs and feed the detector model.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (x_valid) begin
            valid_cnt++;
            if (first_valid < 0) first_valid = cyc;
            seen_bits = {seen_bits[30:0], x};
            hist      = {hist[2:0], x};
            if (hist == 4'b0110) begin
                hits++;
                last_hit = cyc;
            end
        end else if (busy && !done) begin
            idle_busy++;
            if (x !== 1'b1) gap_x_bad++;
        end
        if (frame_start) begin
            fs_cnt++;
            fs_q.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    task automatic applyStimulus(input logic [3:0] pat, input logic [7:0] rep, input logic [3:0] gp);
        pattern    = pat;
        repeat_cnt = rep;
        gap        = gp;
        start      = 1'b1;
        step();
        start      = 1'b0;
        clear_stats();
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            step();
            n++;
        end
        if (done_cnt == 0) checkOutput({tag, "_timeout"}, 0, 1);
    endtask

    logic [4:0] exp_a [6] = '{5'b01110, 5'b11010, 5'b11010, 5'b01010, 5'b10011, 5'b10000};

    initial begin
        reset_n    = 1'b0;
        start      = 1'b1;
        abort      = 1'b0;
        pattern    = 4'b0110;
        repeat_cnt = 8'd1;
        gap        = 4'd0;
        clear_stats();
        step();
        step();
        checkOutput("reset_outs", 32'(outs()), 32'(5'b10000));
        start   = 1'b0;
        reset_n = 1'b1;
        step();
        checkOutput("idle_outs", 32'(outs()), 32'(5'b10000));

        // Single 0110 frame; inputs changed after start must not matter.
        applyStimulus(4'b0110, 8'd1, 4'd0);
        pattern    = 4'b1001;
        repeat_cnt = 8'd0;
        gap        = 4'd7;
        for (int i = 0; i < 6; i++) begin
            step();
            checkOutput($sformatf("A_cycle%0d", i + 1), 32'(outs()), 32'(exp_a[i]));
        end
        checkOutput("A_hits", hits, 1);
        checkOutput("A_hit_cycle", last_hit, 4);

        // Three back-to-back frames.
        applyStimulus(4'b0110, 8'd3, 4'd0);
        wait_done("B", 40);
        checkOutput("B_valid", valid_cnt, 12);
        checkOutput("B_frames", fs_cnt, 3);
        checkOutput("B_fs0", fs_q[0], 1);
        checkOutput("B_fs2", fs_q[2], 9);
        checkOutput("B_hits", hits, 3);
        checkOutput("B_idle", idle_busy, 0);
        checkOutput("B_done_cyc", done_cyc, 13);

        // Two frames separated by a three-cycle gap.
        applyStimulus(4'b0110, 8'd2, 4'd3);
        wait_done("C", 40);
        checkOutput("C_valid", valid_cnt, 8);
        checkOutput("C_gap_cycles", idle_busy, 3);
        checkOutput("C_gap_x", gap_x_bad, 0);
        checkOutput("C_first", first_valid, 1);
        checkOutput("C_fs1", fs_q[1], 8);
        checkOutput("C_done_cyc", done_cyc, 12);

        // Zero repetitions: immediate done.
        applyStimulus(4'b0110, 8'd0, 4'd0);
        step();
        checkOutput("D_cycle1", 32'(outs()), 32'(5'b10011));
        step();
        step();
        checkOutput("D_valid", valid_cnt, 0);
        checkOutput("D_done_cnt", done_cnt, 1);

        // Abort on the second bit, then a normal burst.
        applyStimulus(4'b1001, 8'd5, 4'd0);
        step();
        step();
        abort = 1'b1;
        step();
        checkOutput("E_abort_outs", 32'(outs()), 32'(5'b10000));
        abort = 1'b0;
        step();
        step();
        checkOutput("E_after_outs", 32'(outs()), 32'(5'b10000));
        checkOutput("E_no_done", done_cnt, 0);
        applyStimulus(4'b1011, 8'd1, 4'd2);
        wait_done("E2", 20);
        checkOutput("E2_bits", 32'(seen_bits[3:0]), 32'(4'b1011));
        checkOutput("E2_valid", valid_cnt, 4);

        // Abort beats start in IDLE.
        abort   = 1'b1;
        pattern = 4'b0110;
        start   = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        clear_stats();
        step();
        step();
        checkOutput("F_outs", 32'(outs()), 32'(5'b10000));
        checkOutput("F_valid", valid_cnt, 0);

        // Start during FIN is dropped; start during the done cycle is taken.
        applyStimulus(4'b0110, 8'd1, 4'd0);
        for (int i = 0; i < 4; i++) step();
        start = 1'b1;
        step();
        checkOutput("G_done", 32'(outs()), 32'(5'b10011));
        start = 1'b0;
        step();
        checkOutput("G_c6", 32'(outs()), 32'(5'b10000));
        step();
        checkOutput("G_c7", 32'(outs()), 32'(5'b10000));
        applyStimulus(4'b0110, 8'd1, 4'd0);
        for (int i = 0; i < 5; i++) step();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        checkOutput("G_restart", 32'(outs()), 32'(5'b01110));
        clear_stats();
        wait_done("G", 20);

        // Reset in GAP with start held high throughout.
        applyStimulus(4'b0110, 8'd2, 4'd3);
        start = 1'b1;
        for (int i = 0; i < 5; i++) step();
        reset_n = 1'b0;
        step();
        checkOutput("H_reset1", 32'(outs()), 32'(5'b10000));
        step();
        checkOutput("H_reset2", 32'(outs()), 32'(5'b10000));
        reset_n = 1'b1;
        step();
        checkOutput("H_accept", 32'(outs()), 32'(5'b10000));
        step();
        checkOutput("H_msb", 32'(outs()), 32'(5'b01110));
        start = 1'b0;
        clear_stats();
        wait_done("H", 40);

        // Maximum repeat count must not wrap.
        applyStimulus(4'b1010, 8'd255, 4'd0);
        wait_done("I", 1100);
        checkOutput("I_frames", fs_cnt, 255);
        checkOutput("I_valid", valid_cnt, 1020);
        checkOutput("I_done_cyc", done_cyc, 1021);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
